// File: rtl/clk_enable_gen.sv
// clk_enable_gen: NUM_CH independent clock-enable channels on the system clock.
// Each channel has a runtime-programmable divisor and emits a registered
// one-cycle tick every div clocks; div == 0 disables the channel.
// Global controls: sync (restart all counters in phase) and pause (freeze).
// Optional feature macro: CLKEN_SQUARE_OUT_EN adds per-channel square-wave
// outputs that toggle on every tick; without it sq is tied low.
module clk_enable_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 32,
  parameter int DEFAULT_DIV = 1000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic              sync,
  input  logic              pause,
  output logic [NUM_CH-1:0] tick,
  output logic [DIV_W-1:0]  div_rd,
  output logic [NUM_CH-1:0] sq
);

  logic [DIV_W-1:0]  div_q  [NUM_CH];
  logic [DIV_W-1:0]  div_d  [NUM_CH];
  logic [DIV_W-1:0]  cnt_q  [NUM_CH];
  logic [DIV_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] wr_sel_s;

  // Decode the write strobe to one channel; codes >= NUM_CH select nothing.
  always_comb begin
    wr_sel_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) begin
        wr_sel_s[i] = 1'b1;
      end else begin
        wr_sel_s[i] = 1'b0;
      end
    end
  end

  // Combinational divisor readback; an out-of-range channel reads as zero.
  always_comb begin
    div_rd = {DIV_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ch == CH_W'(i)) begin
        div_rd = div_q[i];
      end
    end
  end

  // Per-channel next state. Priority: sync > write > pause > count.
  // div == 0 is tested before the div-1 compare so it never wraps to all-ones.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      tick_d[i] = 1'b0;
      if (wr_sel_s[i]) begin
        div_d[i] = wr_div;
      end else begin
        div_d[i] = div_q[i];
      end
      if (sync) begin
        cnt_d[i] = {DIV_W{1'b0}};
      end else if (wr_sel_s[i]) begin
        // A written channel restarts; under pause it then stays frozen at 0.
        cnt_d[i] = {DIV_W{1'b0}};
      end else if (pause) begin
        cnt_d[i] = cnt_q[i];
      end else if (div_q[i] == {DIV_W{1'b0}}) begin
        cnt_d[i] = {DIV_W{1'b0}};
      end else if (cnt_q[i] == (div_q[i] - DIV_W'(1))) begin
        cnt_d[i]  = {DIV_W{1'b0}};
        tick_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
    end
  end

  // Divisor, counter and tick registers with asynchronous reset.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(DEFAULT_DIV);
        cnt_q[i] <= {DIV_W{1'b0}};
      end
      tick_q <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef CLKEN_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_q;
  logic [NUM_CH-1:0] sq_d;

  // Square wave toggles on the same edge that registers a tick; sync clears it.
  always_comb begin
    sq_d = sq_q;
    if (sync) begin
      sq_d = {NUM_CH{1'b0}};
    end else begin
      sq_d = sq_q ^ tick_d;
    end
  end

  // Square-wave toggle flops with asynchronous reset.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      sq_q <= {NUM_CH{1'b0}};
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq = sq_q;
`else
  assign sq = {NUM_CH{1'b0}};
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed self-checking bench for clk_enable_gen (10 ns clock).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// "Edge k" below means the k-th rising edge after a sync edge.
module tb_clk_enable_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = 2'd0;
  logic [31:0] wr_div = 32'd0;
  logic        sync = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  tick;
  logic [31:0] div_rd;
  logic [3:0]  sq;

  // Second instance with NUM_CH=3 so an out-of-range channel code exists.
  logic        w2_en = 1'b0;
  logic [1:0]  w2_ch = 2'd0;
  logic [15:0] w2_div = 16'd0;
  logic        sync2 = 1'b0;
  logic        pause2 = 1'b0;
  logic [2:0]  t2;
  logic [15:0] rd2;
  logic [2:0]  sq2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_enable_gen #(.NUM_CH(4), .DIV_W(32), .DEFAULT_DIV(1000)) dut (
    .clk_100mhz(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .sync(sync), .pause(pause), .tick(tick), .div_rd(div_rd), .sq(sq)
  );

  clk_enable_gen #(.NUM_CH(3), .DIV_W(16), .DEFAULT_DIV(5)) dut2 (
    .clk_100mhz(clk), .rst(rst), .wr_en(w2_en), .wr_ch(w2_ch), .wr_div(w2_div),
    .sync(sync2), .pause(pause2), .tick(t2), .div_rd(rd2), .sq(sq2)
  );

  // Called just after a falling edge; the write lands on the next rising edge.
  task automatic write_div(input int ch, input int v);
    wr_en  = 1'b1;
    wr_ch  = 2'(ch);
    wr_div = 32'(v);
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  // Observe n edges after a sync and count deviations from the reference
  // pattern: tick at edges that are multiples of d, sq = floor(k/d) mod 2.
  task automatic scan(input int n, input int divs[4],
                      output int tdev[4], output int sdev[4]);
    logic et, es;
    for (int c = 0; c < 4; c++) begin
      tdev[c] = 0;
      sdev[c] = 0;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        et = (divs[c] != 0) && ((k % divs[c]) == 0);
`ifdef CLKEN_SQUARE_OUT_EN
        es = (divs[c] != 0) && (((k / divs[c]) % 2) == 1);
`else
        es = 1'b0;
`endif
        if (tick[c] !== et) tdev[c]++;
        if (sq[c] !== es) sdev[c]++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (tick !== 4'b0000) begin errors++; $display("FAIL reset_tick: got %b expected 0000", tick); end
    checks++; if (sq !== 4'b0000) begin errors++; $display("FAIL reset_sq: got %b expected 0000", sq); end
    checks++; if (sq2 !== 3'b000) begin errors++; $display("FAIL reset_sq2: got %b expected 000", sq2); end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wr_ch = 2'(c);
      #1;
      checks++; if (div_rd !== 32'd1000) begin errors++; $display("FAIL reset_div_ch%0d: got %0d expected 1000", c, div_rd); end
    end
    @(negedge clk);
    write_div(0, 1);
    repeat (2) @(negedge clk);
    checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL div1_running: got %b expected 1", tick[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tick !== 4'b0000) begin errors++; $display("FAIL async_rst_tick: got %b expected 0000", tick); end
    checks++; if (sq !== 4'b0000) begin errors++; $display("FAIL async_rst_sq: got %b expected 0000", sq); end
    @(negedge clk);
    rst = 1'b0;
    wr_ch = 2'd0;
    #1;
    checks++; if (div_rd !== 32'd1000) begin errors++; $display("FAIL rst_reload_div: got %0d expected 1000", div_rd); end
    @(negedge clk);
  endtask

  task automatic test_period();
    int divs[4];
    int td[4];
    int sd[4];
    divs = '{2, 250, 500, 1000};
    for (int c = 0; c < 4; c++) write_div(c, divs[c]);
    pulse_sync();
    checks++; if (tick !== 4'b0000) begin errors++; $display("FAIL sync_tick_clear: got %b expected 0000", tick); end
    scan(2100, divs, td, sd);
    for (int c = 0; c < 4; c++) begin
      checks++; if (td[c] !== 0) begin errors++; $display("FAIL period_tick_ch%0d: got %0d bad cycles expected 0", c, td[c]); end
      checks++; if (sd[c] !== 0) begin errors++; $display("FAIL period_sq_ch%0d: got %0d bad cycles expected 0", c, sd[c]); end
    end
  endtask

  task automatic test_edge_divisors();
    int divs[4];
    int td[4];
    int sd[4];
    divs = '{1, 0, 7, 13};
    for (int c = 0; c < 4; c++) write_div(c, divs[c]);
    pulse_sync();
    scan(10000, divs, td, sd);
    for (int c = 0; c < 4; c++) begin
      checks++; if (td[c] !== 0) begin errors++; $display("FAIL edge_tick_ch%0d: got %0d bad cycles expected 0", c, td[c]); end
      checks++; if (sd[c] !== 0) begin errors++; $display("FAIL edge_sq_ch%0d: got %0d bad cycles expected 0", c, sd[c]); end
    end
  endtask

  task automatic test_pause();
    int paused_ticks = 0;
    int t0a = -1;
    int t0b = -1;
    int t2a = -1;
    write_div(0, 10);
    pulse_sync();
    repeat (4) @(negedge clk);       // ch0 count is now 4
    pause = 1'b1;
    for (int j = 0; j < 37; j++) begin
      if (j == 20) begin
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 32'd3;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (tick !== 4'b0000) paused_ticks++;
    end
    wr_en = 1'b0;
    pause = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (tick[0]) begin
        if (t0a < 0) t0a = e;
        else if (t0b < 0) t0b = e;
      end
      if (tick[2] && t2a < 0) t2a = e;
    end
    checks++; if (paused_ticks !== 0) begin errors++; $display("FAIL pause_no_ticks: got %0d ticking cycles expected 0", paused_ticks); end
    // Unpaused, ch0 would tick at edge 10; 37 frozen edges move it to 47,
    // which is the 6th edge after release (edges 42..47).
    checks++; if (t0a !== 6) begin errors++; $display("FAIL pause_resume_ch0: got %0d expected 6", t0a); end
    checks++; if (t0b !== 16) begin errors++; $display("FAIL pause_period_ch0: got %0d expected 16", t0b); end
    checks++; if (t2a !== 3) begin errors++; $display("FAIL pause_write_ch2: got %0d expected 3", t2a); end
    wr_ch = 2'd2;
    #1;
    checks++; if (div_rd !== 32'd3) begin errors++; $display("FAIL pause_write_div: got %0d expected 3", div_rd); end
    @(negedge clk);
  endtask

  task automatic test_sync_write();
    int first[4];
    int expd[4];
    expd = '{4, 6, 8, 12};
    write_div(0, 4);
    write_div(1, 6);
    write_div(3, 12);
    pulse_sync();
    repeat (3) @(negedge clk);
    sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd2; wr_div = 32'd8;
    @(negedge clk);
    sync = 1'b0; wr_en = 1'b0;
    checks++; if (tick !== 4'b0000) begin errors++; $display("FAIL syncwr_tick_clear: got %b expected 0000", tick); end
    for (int c = 0; c < 4; c++) first[c] = -1;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (tick[c] && first[c] < 0) first[c] = e;
    end
    for (int c = 0; c < 4; c++) begin
      checks++; if (first[c] !== expd[c]) begin errors++; $display("FAIL syncwr_first_ch%0d: got %0d expected %0d", c, first[c], expd[c]); end
    end
    wr_ch = 2'd2;
    #1;
    checks++; if (div_rd !== 32'd8) begin errors++; $display("FAIL syncwr_div_ch2: got %0d expected 8", div_rd); end
    @(negedge clk);
  endtask

  task automatic test_invalid_channel();
    int a = -1;
    int b = -1;
    w2_en = 1'b1; w2_ch = 2'd3; w2_div = 16'd9;
    @(negedge clk);
    w2_en = 1'b0;
    #1;
    checks++; if (rd2 !== 16'd0) begin errors++; $display("FAIL invalid_rd: got %0d expected 0", rd2); end
    for (int c = 0; c < 3; c++) begin
      w2_ch = 2'(c);
      #1;
      checks++; if (rd2 !== 16'd5) begin errors++; $display("FAIL invalid_keep_ch%0d: got %0d expected 5", c, rd2); end
    end
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (t2[0]) begin
        if (a < 0) a = e;
        else if (b < 0) b = e;
      end
    end
    checks++; if ((a < 0) || (b - a) !== 5) begin errors++; $display("FAIL invalid_period: got %0d expected 5", b - a); end
  endtask

  task automatic test_square();
    int divs[4];
    int td[4];
    int sd[4];
    divs = '{4, 6, 8, 50};
    write_div(3, 50);
    pulse_sync();
    scan(1000, divs, td, sd);
    checks++; if (td[3] !== 0) begin errors++; $display("FAIL square_tick_ch3: got %0d bad cycles expected 0", td[3]); end
    checks++; if (sd[3] !== 0) begin errors++; $display("FAIL square_sq_ch3: got %0d bad cycles expected 0", sd[3]); end
  endtask

  initial begin
    test_reset();
    test_period();
    test_edge_divisors();
    test_pause();
    test_sync_write();
    test_invalid_channel();
    test_square();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
